sdspi_multi_reader: RTL and testbench
=====================================

Name: sdspi_multi_reader

Overview:
- Parametrised successor to the single-sector SD-SPI reader; APB master to the SD-SPI controller.
- Reads a run of N consecutive sectors on one start pulse and packs the bytes into DATA_W-bit words.
- Output words go out on a valid/ready stream, so the RAM copier (boot loader) can apply backpressure.
- Adds a proper APB setup/access phase, timeouts and error reporting.

Parameters:
- DATA_W, 32, output word width; 8, 16 or 32.
- BLOCK_BYTES, 512, sector size in bytes; must be a multiple of DATA_W/8.
- DEV_ADDR, 16'h0000, APB address of the sector-number/command register.
- BLOCK_ADDR, 16'h0200, APB base address of the controller's sector buffer.
- CNT_W, 16, width of the sector-count input.
- TMO_W, 24, width of the busy-wait timeout counter; expiry at all-ones.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- start_sector  in  32  first sector number
- nsectors  in  CNT_W  number of sectors to read
- busy  out  1  high whenever not IDLE
- done  out  1  one-cycle pulse at the end of a run
- error  out  2  0=ok, 1=timeout, 2=pslverr; valid with done, held until next start
- sdspi_status  in  32  [15:8] controller state, [7:0] SD state
- sdsbusy  in  1  controller busy
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  16  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready, pslverr  in  1 each  APB response
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- out_data  out  DATA_W  packed word; byte k of sector in lane k mod (DATA_W/8), little-endian
- out_word  out  CNT_W+9  word index from the start of the run
- out_last  out  1  last word of the run

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset mid-run aborts immediately, with no done pulse.
- Every APB transfer uses a setup cycle (psel=1, penable=0), then an access cycle (penable=1) held until pready. The cycle after pready drops psel and penable.
- pwdata and paddr are stable from setup through access.
- pslverr sampled with pready ends the run: error=2, done pulsed.
- IDLE:
  - On start with nsectors=0: done next cycle, error=0.
  - Otherwise latch sector=start_sector and remaining=nsectors; go to CMD.
  - start while busy is ignored.
- CMD:
  - Wait until sdsbusy=0 and both status bytes are 0.
  - Then APB write pwdata=sector, paddr=DEV_ADDR; go to WAIT_BUSY.
- WAIT_BUSY: wait for sdsbusy=1 and SD state != 0; go to WAIT_IDLE.
- WAIT_IDLE: wait for sdsbusy=0, SD state=0 and controller state=0; clear the byte pointer; go to RD.
- Timeout in WAIT_BUSY and WAIT_IDLE:
  - The timeout counter is cleared on entry to each state.
  - Reaching all-ones gives error=1, done, then IDLE.
- RD: APB read at paddr=BLOCK_ADDR+ptr. On pready, put prdata[7:0] in the lane and increment ptr.
- Word complete (lane full):
  - Assert out_valid and stall further APB reads until out_valid && out_ready.
  - out_data, out_word and out_last are stable while out_valid && !out_ready.
  - A complete word is emitted when ptr reaches BLOCK_BYTES.
- NEXT:
  - When ptr reaches BLOCK_BYTES, decrement remaining and increment sector (32-bit wrap allowed).
  - remaining ≠ 0 → CMD; else DONE.
- DONE: one-cycle done with error=0, then IDLE.
- out_last = 1 on the final word of the final sector only.
- Throughput limit: at most one APB transfer per 3 cycles.

Optional Feature:
- Macro SDSPI_MREADER_RETRY_EN.
- When defined:
  - A timeout or pslverr on a sector restarts that sector from CMD, up to 3 retries per sector.
  - Words already emitted for the failed sector are not re-sent. Bytes are re-read but discarded until ptr passes the last emitted word.
  - The fourth failure reports an error as normal.
  - A 2-bit output retry_cnt gives the total retries in the run, saturating at 3, reset at start.
- When undefined: the first failure terminates the run; no retry_cnt port.

Test Plan:
- Single sector: start_sector=0x100, nsectors=1, DATA_W=32, buffer byte i = i&0xFF → 128 words; word0=0x03020100, word127=0xFFFEFDFC with out_last=1; done with error=0; one APB write of 0x100 to DEV_ADDR.
- Multi sector: nsectors=3 from 0xFFFFFFFF → APB writes 0xFFFFFFFF, 0x0, 0x1; 384 words; out_word runs 0..383.
- Backpressure: out_ready toggles 1-in-4 → no word lost or duplicated, out_data stable while stalled, no APB read issued while out_valid && !out_ready.
- Timeout: sdsbusy never rises, TMO_W=8 → done with error=1 about 255 cycles after the command write; busy then 0.
- pslverr on the 5th read of sector 0 → error=2 and 1 word emitted; with SDSPI_MREADER_RETRY_EN the sector completes, 128 unique words, retry_cnt=1.
- nsectors=0 → done one cycle after start; no APB activity. Reset asserted mid-read → all outputs 0 next cycle.

Source files
------------

// File: rtl/sdspi_multi_reader.sv
// sdspi_multi_reader
//
// Purpose:
//   APB master that drives an SD-SPI controller to read a run of consecutive
//   sectors from one start pulse. The bytes of each sector are packed
//   little-endian into DATA_W-bit words and sent out on a valid/ready stream,
//   so the downstream RAM copier can apply backpressure.
//
// Ports:
//   clk, rstn          system clock, asynchronous active-low reset
//   start              one-cycle request, honoured only while idle
//   start_sector       first sector number of the run
//   nsectors           number of sectors in the run (0 = finish at once)
//   busy               high whenever a run is in progress
//   done               one-cycle pulse at the end of a run
//   error              0 ok, 1 timeout, 2 pslverr; held until the next start
//   sdspi_status       controller state [15:8], SD state [7:0]
//   sdsbusy            controller busy flag
//   psel .. pslverr    APB master interface to the controller
//   out_valid/ready    output word handshake
//   out_data           packed word, sector byte k in lane k mod (DATA_W/8)
//   out_word           index of the word from the start of the run
//   out_last           marks the final word of the final sector
//   retry_cnt          total retries in the run (retry build only)
//
// Configuration macro:
//   SDSPI_MREADER_RETRY_EN - a failed sector is restarted from the command
//   write up to three times; words already emitted are not sent again.

module sdspi_multi_reader #(
    parameter int          DATA_W      = 32,
    parameter int          BLOCK_BYTES = 512,
    parameter logic [15:0] DEV_ADDR    = 16'h0000,
    parameter logic [15:0] BLOCK_ADDR  = 16'h0200,
    parameter int          CNT_W       = 16,
    parameter int          TMO_W       = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [31:0]         start_sector,
    input  logic [CNT_W-1:0]    nsectors,
    output logic                busy,
    output logic                done,
    output logic [1:0]          error,
    input  logic [31:0]         sdspi_status,
    input  logic                sdsbusy,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [15:0]         paddr,
    output logic [31:0]         pwdata,
    input  logic [31:0]         prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CNT_W+8:0]    out_word,
`ifdef SDSPI_MREADER_RETRY_EN
    output logic [1:0]          retry_cnt,
`endif
    output logic                out_last
);

    localparam int BPW    = DATA_W / 8;
    localparam int PTR_W  = $clog2(BLOCK_BYTES) + 1;
    localparam int WORD_W = CNT_W + 9;
    localparam logic [PTR_W-1:0] LANE_MASK = PTR_W'(BPW - 1);
    localparam logic [PTR_W-1:0] PTR_END   = PTR_W'(BLOCK_BYTES);
    localparam logic [PTR_W-1:0] PTR_FINAL = PTR_W'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_RD,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         sector_q, sector_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic [1:0]          error_q, error_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [15:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;

`ifdef SDSPI_MREADER_RETRY_EN
    logic [1:0]          sec_retry_q, sec_retry_d;
    logic [1:0]          retry_cnt_q, retry_cnt_d;
    logic [PTR_W-1:0]    emitted_q, emitted_d;
`endif

    logic                apb_done;
    logic                fail;
    logic [1:0]          fail_code;
    logic                keep;
    logic                unused_bits;

    assign apb_done    = psel_q && penable_q && pready;
    assign unused_bits = ^{prdata[31:8], sdspi_status[31:16]};

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign error     = error_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_word  = word_q;
    assign out_last  = out_last_q;
`ifdef SDSPI_MREADER_RETRY_EN
    assign retry_cnt = retry_cnt_q;
`endif

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            sector_q    <= '0;
            remaining_q <= '0;
            ptr_q       <= '0;
            tmo_q       <= '0;
            data_q      <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 2'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef SDSPI_MREADER_RETRY_EN
            sec_retry_q <= 2'd0;
            retry_cnt_q <= 2'd0;
            emitted_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sector_q    <= sector_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            tmo_q       <= tmo_d;
            data_q      <= data_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            error_q     <= error_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
`ifdef SDSPI_MREADER_RETRY_EN
            sec_retry_q <= sec_retry_d;
            retry_cnt_q <= retry_cnt_d;
            emitted_q   <= emitted_d;
`endif
        end
    end

    // Next-state logic. New APB transfers are only launched while psel is
    // low, which leaves one idle cycle after every pready and so limits the
    // bus to one transfer per three cycles.
    always_comb begin
        state_d     = state_q;
        sector_d    = sector_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        tmo_d       = tmo_q;
        data_d      = data_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        error_d     = error_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        fail        = 1'b0;
        fail_code   = 2'd0;
        keep        = 1'b1;
`ifdef SDSPI_MREADER_RETRY_EN
        sec_retry_d = sec_retry_q;
        retry_cnt_d = retry_cnt_q;
        emitted_d   = emitted_q;
        // Bytes below the last emitted word are re-read after a retry but dropped.
        keep        = (ptr_q >= emitted_q);
`endif

        if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end
        if (apb_done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            word_d      = word_q + WORD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    error_d = 2'd0;
                    word_d  = '0;
`ifdef SDSPI_MREADER_RETRY_EN
                    sec_retry_d = 2'd0;
                    retry_cnt_d = 2'd0;
                    emitted_d   = '0;
`endif
                    if (nsectors == '0) begin
                        done_d = 1'b1;
                    end else begin
                        sector_d    = start_sector;
                        remaining_d = nsectors;
                        state_d     = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (apb_done) begin
                    if (pslverr) begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
                    end else begin
                        state_d = ST_WAIT_BUSY;
                        tmo_d   = '0;
                    end
                end else if (!psel_q && !sdsbusy && sdspi_status[15:0] == 16'd0) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                    paddr_d   = DEV_ADDR;
                    pwdata_d  = sector_q;
                end
            end
            ST_WAIT_BUSY: begin
                if (sdsbusy && sdspi_status[7:0] != 8'd0) begin
                    state_d = ST_WAIT_IDLE;
                    tmo_d   = '0;
                end else if (&tmo_q) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (!sdsbusy && sdspi_status[15:0] == 16'd0) begin
                    state_d = ST_RD;
                    ptr_d   = '0;
                end else if (&tmo_q) begin
                    fail      = 1'b1;
                    fail_code = 2'd1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RD: begin
                if (apb_done) begin
                    if (pslverr) begin
                        fail      = 1'b1;
                        fail_code = 2'd2;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                        if (keep) begin
                            for (int k = 0; k < BPW; k++) begin
                                if ((ptr_q & LANE_MASK) == PTR_W'(k)) begin
                                    data_d[8*k +: 8] = prdata[7:0];
                                end
                            end
                            if ((ptr_q & LANE_MASK) == LANE_MASK) begin
                                out_valid_d = 1'b1;
                                out_last_d  = (remaining_q == CNT_W'(1)) && (ptr_q == PTR_FINAL);
`ifdef SDSPI_MREADER_RETRY_EN
                                emitted_d   = ptr_q + PTR_W'(1);
`endif
                            end
                        end
                    end
                end else if (!psel_q && !out_valid_q) begin
                    // The sector ends only once its final word has been taken.
                    if (ptr_q == PTR_END) begin
                        state_d = ST_NEXT;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b0;
                        paddr_d   = BLOCK_ADDR + 16'(ptr_q);
                    end
                end
            end
            ST_NEXT: begin
                remaining_d = remaining_q - CNT_W'(1);
                sector_d    = sector_q + 32'd1;
`ifdef SDSPI_MREADER_RETRY_EN
                sec_retry_d = 2'd0;
                emitted_d   = '0;
`endif
                state_d = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_CMD;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Failure handling: either retry the sector or end the run with an error.
        if (fail) begin
`ifdef SDSPI_MREADER_RETRY_EN
            if (sec_retry_q != 2'd3) begin
                sec_retry_d = sec_retry_q + 2'd1;
                if (retry_cnt_q != 2'd3) begin
                    retry_cnt_d = retry_cnt_q + 2'd1;
                end
                state_d = ST_CMD;
            end else begin
                error_d = fail_code;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
`else
            error_d = fail_code;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
        end
    end

endmodule

// File: tb/tb_sdspi_multi_reader.sv
// tb_sdspi_multi_reader
//
// Purpose:
//   Self-checking bench for sdspi_multi_reader. A behavioural SD-SPI
//   controller answers the APB transfers; each sector buffer byte at offset i
//   holds (i + sector[7:0]) & 0xFF. Expected words and done/error results are
//   queued when a run is started and a monitor pops and compares them as the
//   design presents them.

module tb_sdspi_multi_reader;

    localparam int DATA_W      = 32;
    localparam int BLOCK_BYTES = 512;
    localparam int CNT_W       = 16;
    localparam int TMO_W       = 8;
    localparam int BPW         = DATA_W / 8;
    localparam int WPS         = BLOCK_BYTES / BPW;
    localparam int WORD_W      = CNT_W + 9;
    localparam logic [15:0] DEV_ADDR   = 16'h0000;
    localparam logic [15:0] BLOCK_ADDR = 16'h0200;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [WORD_W-1:0] word;
        logic              last;
    } exp_word_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       start_sector = '0;
    logic [CNT_W-1:0]  nsectors = '0;
    logic              busy;
    logic              done;
    logic [1:0]        error;
    logic [31:0]       sdspi_status = '0;
    logic              sdsbusy = 1'b0;
    logic              psel, penable, pwrite;
    logic [15:0]       paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic [WORD_W-1:0] out_word;
    logic              out_last;
`ifdef SDSPI_MREADER_RETRY_EN
    logic [1:0]        retry_cnt;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    exp_word_t   exp_q[$];
    logic [1:0]  err_q[$];
    logic [47:0] wr_log[$];

    logic [31:0] cur_sector = '0;
    int          run_reads = 0;
    int          inject_read = 0;
    bit          never_busy = 1'b0;
    int          ctl_phase = 0;
    int          ctl_cnt = 0;
    int          acc_wait = 0;
    int          ready_mode = 0;
    int          cycle_cnt = 0;
    int          wr_cycle = 0;
    int          done_cycle = 0;
    int          done_seen = 0;
    int          words_seen = 0;
    int          setup_cnt = 0;
    logic [15:0] setup_addr = '0;
    logic [31:0] setup_wdata = '0;
    logic [DATA_W-1:0] first_data = '0;
    logic [DATA_W-1:0] last_data = '0;
    logic        last_flag_seen = 1'b0;
    logic        held = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic [WORD_W-1:0] held_word = '0;
    logic        held_last = 1'b0;

    sdspi_multi_reader #(
        .DATA_W(DATA_W), .BLOCK_BYTES(BLOCK_BYTES), .DEV_ADDR(DEV_ADDR),
        .BLOCK_ADDR(BLOCK_ADDR), .CNT_W(CNT_W), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .start_sector(start_sector),
        .nsectors(nsectors), .busy(busy), .done(done), .error(error),
        .sdspi_status(sdspi_status), .sdsbusy(sdsbusy), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_word(out_word),
`ifdef SDSPI_MREADER_RETRY_EN
        .retry_cnt(retry_cnt),
`endif
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Sink readiness: always ready, or ready one cycle in four.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else out_ready = (cycle_cnt % 4 == 0);
    end

    // Controller model: APB slave with occasional wait states plus the
    // busy/status sequence that follows a command write.
    always @(negedge clk) begin
        if (!rstn) begin
            pready = 1'b0; pslverr = 1'b0; prdata = '0;
            sdsbusy = 1'b0; sdspi_status = '0;
            ctl_phase = 0; ctl_cnt = 0; acc_wait = 0;
        end else begin
            if (psel && !penable) begin
                setup_addr  = paddr;
                setup_wdata = pwdata;
                setup_cnt++;
                if (!pwrite) checkOutput("rd_while_stalled", 64'(out_valid && !out_ready), 64'd0);
            end
            if (psel && penable) begin
                checkOutput("paddr_stable", 64'(paddr), 64'(setup_addr));
                if (pwrite) checkOutput("pwdata_stable", 64'(pwdata), 64'(setup_wdata));
            end
            if (pready) begin
                pready = 1'b0; pslverr = 1'b0;
            end else if (psel && penable) begin
                if (acc_wait < ((run_reads % 4 == 1) ? 1 : 0)) begin
                    acc_wait++;
                end else begin
                    acc_wait = 0;
                    pready = 1'b1;
                    if (pwrite) begin
                        wr_log.push_back({paddr, pwdata});
                        cur_sector = pwdata;
                        wr_cycle   = cycle_cnt;
                        if (!never_busy) begin ctl_phase = 1; ctl_cnt = 0; end
                    end else begin
                        run_reads++;
                        prdata = {24'h0, 8'(int'(paddr - BLOCK_ADDR) + int'(cur_sector[7:0]))};
                        if (run_reads == inject_read) begin
                            pslverr = 1'b1;
                            inject_read = 0;
                        end
                    end
                end
            end
            case (ctl_phase)
                1: begin
                    ctl_cnt++;
                    if (ctl_cnt == 3) begin
                        sdsbusy = 1'b1; sdspi_status = 32'h0000_0203;
                        ctl_phase = 2; ctl_cnt = 0;
                    end
                end
                2: begin
                    ctl_cnt++;
                    if (ctl_cnt == 20) begin
                        sdsbusy = 1'b0; sdspi_status = '0; ctl_phase = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted word and every done.
    always @(negedge clk) begin
        if (!rstn) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_data", 64'(out_data), 64'(held_data));
                checkOutput("stall_word", 64'(out_word), 64'(held_word));
                checkOutput("stall_last", 64'(out_last), 64'(held_last));
            end
            held = 1'b0;
            if (out_valid && !out_ready) begin
                held = 1'b1; held_data = out_data; held_word = out_word; held_last = out_last;
            end else if (out_valid && out_ready) begin
                checkOutput("sb_word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_word_t e;
                    e = exp_q.pop_front();
                    checkOutput("word_data", 64'(out_data), 64'(e.data));
                    checkOutput("word_index", 64'(out_word), 64'(e.word));
                    checkOutput("word_last", 64'(out_last), 64'(e.last));
                end
                if (words_seen == 0) first_data = out_data;
                if (out_last) begin last_data = out_data; last_flag_seen = 1'b1; end
                words_seen++;
            end
            if (done) begin
                done_seen++;
                done_cycle = cycle_cnt;
                checkOutput("sb_done_expected", 64'(err_q.size() != 0), 64'd1);
                if (err_q.size() != 0) checkOutput("done_error", 64'(error), 64'(err_q.pop_front()));
            end
        end
    end

    // Queue the expected words of a run, start it and wait (bounded) for done.
    task automatic applyStimulus(input logic [31:0] sec, input int n, input int n_words,
                                 input logic [1:0] exp_err, input int inject,
                                 input bit no_busy, input int rmode);
        int d0;
        int budget;
        for (int k = 0; k < n_words; k++) begin
            exp_word_t e;
            logic [31:0] s;
            s = sec + 32'(k / WPS);
            for (int j = 0; j < BPW; j++) begin
                e.data[8*j +: 8] = 8'((k % WPS) * BPW + j + int'(s[7:0]));
            end
            e.word = WORD_W'(k);
            e.last = (k == n * WPS - 1);
            exp_q.push_back(e);
        end
        err_q.push_back(exp_err);
        wr_log.delete();
        run_reads = 0; inject_read = inject; never_busy = no_busy; ready_mode = rmode;
        words_seen = 0; last_flag_seen = 1'b0;
        d0 = done_seen;
        @(negedge clk);
        start_sector = sec; nsectors = CNT_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (done_seen == d0 && budget < 8000) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("done_reached", 64'(done_seen != d0), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("error_held", 64'(error), 64'(exp_err));
        checkOutput("words_remaining", 64'(exp_q.size()), 64'd0);
        checkOutput("words_count", 64'(words_seen), 64'(n_words));
        exp_q.delete();
        err_q.delete();
        ready_mode = 0; never_busy = 1'b0;
    endtask

    initial begin
        int d0;
        int s0;
        int budget;

        // Reset values
        #2;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_psel", 64'(psel), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // nsectors = 0: done the cycle after start, no APB traffic
        $display("[TB] zero-sector run");
        d0 = done_seen; s0 = setup_cnt;
        err_q.push_back(2'd0);
        start_sector = 32'h1234; nsectors = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        checkOutput("zero_done_latency", 64'(done_seen - d0), 64'd1);
        checkOutput("zero_no_apb", 64'(setup_cnt - s0), 64'd0);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        err_q.delete();

        // Single sector
        $display("[TB] single sector");
        applyStimulus(32'h100, 1, WPS, 2'd0, 0, 1'b0, 0);
        checkOutput("single_wr_count", 64'(wr_log.size()), 64'd1);
        checkOutput("single_wr0", 64'(wr_log[0]), 64'({DEV_ADDR, 32'h0000_0100}));
        checkOutput("single_word0", 64'(first_data), 64'h0302_0100);
        checkOutput("single_word127", 64'(last_data), 64'hFFFE_FDFC);
        checkOutput("single_last_seen", 64'(last_flag_seen), 64'd1);

        // Multi sector across the 32-bit wrap, with a start pulse while busy
        $display("[TB] multi sector");
        fork
            begin
                repeat (300) @(negedge clk);
                start_sector = 32'h55; nsectors = CNT_W'(5); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        applyStimulus(32'hFFFF_FFFF, 3, 3 * WPS, 2'd0, 0, 1'b0, 0);
        checkOutput("multi_wr_count", 64'(wr_log.size()), 64'd3);
        checkOutput("multi_wr0", 64'(wr_log[0]), 64'({DEV_ADDR, 32'hFFFF_FFFF}));
        checkOutput("multi_wr1", 64'(wr_log[1]), 64'({DEV_ADDR, 32'h0000_0000}));
        checkOutput("multi_wr2", 64'(wr_log[2]), 64'({DEV_ADDR, 32'h0000_0001}));

        // Backpressure: sink ready one cycle in four
        $display("[TB] backpressure");
        applyStimulus(32'h0000_0042, 1, WPS, 2'd0, 0, 1'b0, 1);
        checkOutput("bp_wr_count", 64'(wr_log.size()), 64'd1);

        // pslverr on the fifth read of sector 0
        $display("[TB] pslverr");
`ifdef SDSPI_MREADER_RETRY_EN
        applyStimulus(32'h0, 1, WPS, 2'd0, 5, 1'b0, 0);
        checkOutput("slverr_retry_cnt", 64'(retry_cnt), 64'd1);
        checkOutput("slverr_wr_count", 64'(wr_log.size()), 64'd2);
`else
        applyStimulus(32'h0, 1, 1, 2'd2, 5, 1'b0, 0);
        checkOutput("slverr_wr_count", 64'(wr_log.size()), 64'd1);
`endif
        checkOutput("slverr_word0", 64'(first_data), 64'h0302_0100);

        // Timeout: controller never raises busy
        $display("[TB] timeout");
        applyStimulus(32'h20, 1, 0, 2'd1, 0, 1'b1, 0);
        checkOutput("tmo_latency", 64'((done_cycle - wr_cycle) >= 250 && (done_cycle - wr_cycle) <= 265), 64'd1);
`ifdef SDSPI_MREADER_RETRY_EN
        checkOutput("tmo_wr_count", 64'(wr_log.size()), 64'd4);
        checkOutput("tmo_retry_cnt", 64'(retry_cnt), 64'd3);
`else
        checkOutput("tmo_wr_count", 64'(wr_log.size()), 64'd1);
`endif

        // Reset in the middle of a read
        $display("[TB] reset mid-run");
        for (int k = 0; k < WPS; k++) begin
            exp_word_t e;
            for (int j = 0; j < BPW; j++) e.data[8*j +: 8] = 8'(k * BPW + j);
            e.word = WORD_W'(k);
            e.last = (k == WPS - 1);
            exp_q.push_back(e);
        end
        run_reads = 0; words_seen = 0; d0 = done_seen;
        @(negedge clk);
        start_sector = 32'h0; nsectors = CNT_W'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (words_seen < 3 && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("rst_mid_words", 64'(words_seen >= 3), 64'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("rstmid_busy", 64'(busy), 64'd0);
        checkOutput("rstmid_done", 64'(done), 64'd0);
        checkOutput("rstmid_error", 64'(error), 64'd0);
        checkOutput("rstmid_apb", 64'({psel, penable, pwrite}), 64'd0);
        checkOutput("rstmid_paddr", 64'(paddr), 64'd0);
        checkOutput("rstmid_pwdata", 64'(pwdata), 64'd0);
        checkOutput("rstmid_out", 64'({out_valid, out_last}), 64'd0);
        checkOutput("rstmid_data", 64'(out_data), 64'd0);
        checkOutput("rstmid_word", 64'(out_word), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        checkOutput("rstmid_no_done", 64'(done_seen), 64'(d0));
        checkOutput("rstmid_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
